gb_bus_write_sync: RTL and testbench

Front-end stage between the raw Game Boy cartridge bus and the MBC5 mapper register logic. It synchronises the asynchronous bus strobes and address/data lines into the CPLD clock domain and filters glitches. It emits exactly one single-cycle write event per valid write cycle, carrying the address nibble and data byte. It also exports a synchronised read-activity flag so the mapper can drive banked address and RAM chip-enable from clean state.

---
 rtl/mbc_bus_pkg.sv | 30 +++
 rtl/gb_sync_ff.sv | 22 ++
 rtl/gb_bus_write_sync.sv | 137 +++++++++++++
 tb/tb_gb_bus_write_sync.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mbc_bus_pkg.sv
// Shared types and constants for the cartridge bus front-end
// feeding the MBC5 mapper.
package mbc_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WR_LOW,
    WR_ARMED,
    COMMIT
  } wr_state_e;

  localparam int DATA_BITS_DEF = 8;

  localparam logic [3:0] ROM_LAST = 4'h7;
  localparam logic [3:0] RAM_LO   = 4'hA;
  localparam logic [3:0] RAM_HI   = 4'hB;

  function automatic logic is_rom_nib(
    input logic [3:0] a
  );
    return a <= ROM_LAST;
  endfunction

  function automatic logic is_ram_nib(
    input logic [3:0] a
  );
    return (a == RAM_LO) || (a == RAM_HI);
  endfunction

endpackage

// File: rtl/gb_sync_ff.sv
// N-stage synchroniser for an asynchronous bus strobe,
// preset to a known level in reset.
module gb_sync_ff #(
  parameter int   N      = 2,
  parameter logic PRESET = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic [N-1:0] r_sync;

  always_ff @(posedge clock) begin
    if (!reset) r_sync <= {N{PRESET}};
    else        r_sync <= {r_sync[N-2:0], i_d};
  end

  assign o_q = r_sync[N-1];

endmodule

// File: rtl/gb_bus_write_sync.sv
// Cartridge bus write synchroniser: filters WR glitches and
// emits one clean write event per accepted bus write.
module gb_bus_write_sync
  import mbc_bus_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 2,
  parameter int DATA_BITS     = DATA_BITS_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [3:0]           bus_a,
  input  logic [DATA_BITS-1:0] bus_d,
  input  logic                 bus_wr_n,
  input  logic                 bus_rd_n,
  output logic                 wr_strobe,
  output logic [3:0]           wr_addr,
  output logic [DATA_BITS-1:0] wr_data,
  output logic                 rd_active,
  output logic [7:0]           glitch_count,
  output logic                 conflict
);

  localparam logic [2:0] FILT = 3'(FILTER_CYCLES);

  logic                 w_wr_s;
  logic                 w_rd_s;
  logic [3:0]           r_a_cap;
  logic [DATA_BITS-1:0] r_d_cap;
  logic [3:0]           r_hold_a;
  logic [DATA_BITS-1:0] r_hold_d;
  wr_state_e            r_state;
  wr_state_e            w_next;
  logic [2:0]           r_cnt;
  logic [2:0]           w_cnt_next;
  logic [2:0]           w_cnt_inc;
  logic                 w_load;
  logic                 w_glitch;
  logic                 r_wr_strobe;
  logic [3:0]           r_wr_addr;
  logic [DATA_BITS-1:0] r_wr_data;
  logic                 r_rd_active;
  logic [7:0]           r_glitch;
  logic                 r_conflict;

  gb_sync_ff #(.N(SYNC_STAGES), .PRESET(1'b1)) u_wr_sync (
    .clock (clock),
    .reset (reset),
    .i_d   (bus_wr_n),
    .o_q   (w_wr_s)
  );

  gb_sync_ff #(.N(SYNC_STAGES), .PRESET(1'b1)) u_rd_sync (
    .clock (clock),
    .reset (reset),
    .i_d   (bus_rd_n),
    .o_q   (w_rd_s)
  );

  assign w_cnt_inc = r_cnt + 3'd1;

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_load     = 1'b0;
    w_glitch   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!w_wr_s) begin
          w_load     = 1'b1;
          w_cnt_next = 3'd1;
          w_next     = (FILT <= 3'd1) ? WR_ARMED : WR_LOW;
        end
      end
      WR_LOW: begin
        if (!w_wr_s) begin
          w_load     = 1'b1;
          w_cnt_next = w_cnt_inc;
          if (w_cnt_inc >= FILT) w_next = WR_ARMED;
        end else begin
          w_glitch = 1'b1;
          w_next   = IDLE;
        end
      end
      WR_ARMED: begin
        // keep reloading so the final low sample wins
        if (!w_wr_s) w_load = 1'b1;
        else         w_next = COMMIT;
      end
      COMMIT:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_cnt       <= 3'd0;
      r_a_cap     <= 4'd0;
      r_d_cap     <= '0;
      r_hold_a    <= 4'd0;
      r_hold_d    <= '0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= 4'd0;
      r_wr_data   <= '0;
      r_rd_active <= 1'b0;
      r_glitch    <= 8'd0;
      r_conflict  <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_cnt       <= w_cnt_next;
      r_a_cap     <= bus_a;
      r_d_cap     <= bus_d;
      if (w_load) begin
        r_hold_a <= r_a_cap;
        r_hold_d <= r_d_cap;
      end
      r_wr_strobe <= (r_state == COMMIT);
      if (r_state == COMMIT) begin
        r_wr_addr <= r_hold_a;
        r_wr_data <= r_hold_d;
      end
      r_rd_active <= !w_rd_s && (r_state == IDLE);
      if (w_glitch && (r_glitch != 8'hFF))
        r_glitch <= r_glitch + 8'd1;
      if (!w_rd_s && !w_wr_s) r_conflict <= 1'b1;
    end
  end

  assign wr_strobe    = r_wr_strobe;
  assign wr_addr      = r_wr_addr;
  assign wr_data      = r_wr_data;
  assign rd_active    = r_rd_active;
  assign glitch_count = r_glitch;
  assign conflict     = r_conflict;

endmodule

// File: tb/tb_gb_bus_write_sync.sv
// Bench for gb_bus_write_sync: vector table, scoreboard of
// expected write events, and hand sequences for corner cases.
module tb_gb_bus_write_sync;

  localparam int SS = 2;
  localparam int FC = 2;
  localparam int DB = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic [3:0]    bus_a;
  logic [DB-1:0] bus_d;
  logic          bus_wr_n;
  logic          bus_rd_n;
  logic          wr_strobe;
  logic [3:0]    wr_addr;
  logic [DB-1:0] wr_data;
  logic          rd_active;
  logic [7:0]    glitch_count;
  logic          conflict;

  always #5 clock = ~clock;

  gb_bus_write_sync #(
    .SYNC_STAGES   (SS),
    .FILTER_CYCLES (FC),
    .DATA_BITS     (DB)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .bus_a        (bus_a),
    .bus_d        (bus_d),
    .bus_wr_n     (bus_wr_n),
    .bus_rd_n     (bus_rd_n),
    .wr_strobe    (wr_strobe),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .rd_active    (rd_active),
    .glitch_count (glitch_count),
    .conflict     (conflict)
  );

  typedef struct {
    logic [3:0] a;
    logic [7:0] d;
    int         low;
    bit         accept;
  } vec_t;

  typedef struct {
    logic [3:0] a;
    logic [7:0] d;
  } exp_t;

  exp_t sb[$];
  int   checks      = 0;
  int   failures    = 0;
  int   strobes     = 0;
  int   exp_strobes = 0;
  int   exp_glitch  = 0;

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] req
  );
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h",
               name, act, req);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic expect_wr(
    input logic [3:0] a,
    input logic [7:0] d
  );
    exp_t e;
    e.a = a;
    e.d = d;
    sb.push_back(e);
    exp_strobes++;
  endtask

  task automatic do_write(
    input logic [3:0] a,
    input logic [7:0] d,
    input int         low,
    input bit         accept
  );
    if (accept) expect_wr(a, d);
    bus_a    = a;
    bus_d    = d;
    bus_wr_n = 1'b0;
    cyc(low);
    bus_wr_n = 1'b1;
    cyc(8);
  endtask

  always @(negedge clock) begin : mon
    exp_t e;
    if (wr_strobe === 1'b1) begin
      strobes++;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_strobe: got a=%0h d=%0h required none",
                 wr_addr, wr_data);
      end else begin
        e = sb.pop_front();
        if (wr_addr !== e.a || wr_data !== e.d) begin
          failures++;
          $display("FAIL strobe_value: got a=%0h d=%0h required a=%0h d=%0h",
                   wr_addr, wr_data, e.a, e.d);
        end
      end
    end
  end

  vec_t vecs[6];
  int   seen_at;
  int   n_seen;
  int   s0;

  initial begin
    vecs[0] = '{4'h2, 8'h05, 6, 1'b1};
    vecs[1] = '{4'hA, 8'h3C, 2, 1'b1};
    vecs[2] = '{4'hB, 8'hFF, 1, 1'b0};
    vecs[3] = '{4'h0, 8'h0A, 3, 1'b1};
    vecs[4] = '{4'h7, 8'h80, 1, 1'b0};
    vecs[5] = '{4'h4, 8'h03, 10, 1'b1};

    reset    = 1'b0;
    bus_a    = 4'h0;
    bus_d    = 8'h00;
    bus_wr_n = 1'b1;
    bus_rd_n = 1'b1;
    cyc(3);
    chk("rst_strobe", 32'(wr_strobe), 0);
    chk("rst_addr", 32'(wr_addr), 0);
    chk("rst_data", 32'(wr_data), 0);
    chk("rst_rd_active", 32'(rd_active), 0);
    chk("rst_glitch", 32'(glitch_count), 0);
    chk("rst_conflict", 32'(conflict), 0);
    reset = 1'b1;
    cyc(3);

    // single write: strobe SS+1 posedges after the WR-high sample
    expect_wr(4'h2, 8'h05);
    bus_a    = 4'h2;
    bus_d    = 8'h05;
    bus_wr_n = 1'b0;
    cyc(6);
    bus_wr_n = 1'b1;
    seen_at  = 0;
    n_seen   = 0;
    for (int k = 1; k <= 7; k++) begin
      cyc(1);
      if (wr_strobe === 1'b1) begin
        if (seen_at == 0) seen_at = k;
        n_seen++;
      end
    end
    chk("strobe_latency", 32'(seen_at), 32'(SS + 2));
    chk("strobe_once", 32'(n_seen), 1);
    cyc(3);

    for (int i = 0; i < 6; i++) begin
      do_write(vecs[i].a, vecs[i].d, vecs[i].low,
               vecs[i].accept);
      if (!vecs[i].accept) exp_glitch++;
      chk("vec_glitch_count", 32'(glitch_count),
          32'(exp_glitch));
    end

    // late data: data settles one clock before WR rises
    expect_wr(4'h3, 8'h0A);
    bus_a    = 4'h3;
    bus_d    = 8'h00;
    bus_wr_n = 1'b0;
    cyc(5);
    bus_d = 8'h0A;
    cyc(1);
    bus_wr_n = 1'b1;
    cyc(8);

    // back-to-back with a one-clock WR-high gap
    s0 = strobes;
    expect_wr(4'h0, 8'h0A);
    expect_wr(4'h4, 8'h03);
    bus_a    = 4'h0;
    bus_d    = 8'h0A;
    bus_wr_n = 1'b0;
    cyc(3);
    bus_wr_n = 1'b1;
    cyc(1);
    bus_a    = 4'h4;
    bus_d    = 8'h03;
    bus_wr_n = 1'b0;
    cyc(3);
    bus_wr_n = 1'b1;
    cyc(10);
    chk("b2b_strobes", 32'(strobes - s0), 2);
    chk("b2b_drained", 32'(sb.size()), 0);

    bus_rd_n = 1'b0;
    cyc(2);
    chk("rd_active_early", 32'(rd_active), 0);
    cyc(1);
    chk("rd_active_on", 32'(rd_active), 1);
    bus_rd_n = 1'b1;
    cyc(4);
    chk("rd_active_off", 32'(rd_active), 0);
    chk("no_conflict_yet", 32'(conflict), 0);

    // RD and WR low together: sticky flag, write still commits
    expect_wr(4'hB, 8'h55);
    bus_a    = 4'hB;
    bus_d    = 8'h55;
    bus_rd_n = 1'b0;
    bus_wr_n = 1'b0;
    cyc(4);
    bus_rd_n = 1'b1;
    bus_wr_n = 1'b1;
    cyc(8);
    chk("conflict_sticky", 32'(conflict), 1);

    for (int i = 0; i < 300; i++) begin
      bus_a    = 4'h1;
      bus_wr_n = 1'b0;
      cyc(1);
      bus_wr_n = 1'b1;
      cyc(3);
      if (exp_glitch < 255) exp_glitch++;
    end
    cyc(4);
    chk("glitch_saturate", 32'(glitch_count),
        32'(exp_glitch));

    // reset while armed: write is dropped
    bus_a    = 4'h5;
    bus_d    = 8'h77;
    bus_wr_n = 1'b0;
    cyc(5);
    reset = 1'b0;
    cyc(1);
    bus_wr_n = 1'b1;
    cyc(2);
    chk("mid_rst_strobe", 32'(wr_strobe), 0);
    chk("mid_rst_addr", 32'(wr_addr), 0);
    chk("mid_rst_data", 32'(wr_data), 0);
    chk("mid_rst_glitch", 32'(glitch_count), 0);
    chk("mid_rst_conflict", 32'(conflict), 0);
    reset = 1'b1;
    cyc(10);
    do_write(4'hA, 8'h42, 4, 1'b1);

    cyc(4);
    chk("sb_empty", 32'(sb.size()), 0);
    chk("strobe_total", 32'(strobes), 32'(exp_strobes));

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
